// File: rtl/direct_mapped_cache_pkg.sv
// rtl/direct_mapped_cache_pkg.sv - shared widths and FSM encoding for the direct-mapped cache
package direct_mapped_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } cache_state_t;

  localparam int ADDR_W     = 30;
  localparam int OFFSET_W   = 2;
  localparam int INDEX_W    = 3;
  localparam int TAG_W      = 25;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = 128;
  localparam int MEM_ADDR_W = ADDR_W - OFFSET_W;

endpackage

// File: rtl/direct_mapped_cache.sv
// rtl/direct_mapped_cache.sv - write-back, write-allocate direct-mapped cache with one-line memory port
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   proc_read/write   processor request (both high = write)
//   proc_addr         30-bit word address {tag, index, offset}
//   proc_wdata        write word
//   proc_stall        request not complete this cycle
//   proc_rdata        read word, valid when proc_read & ~proc_stall
//   mem_read/write    line fetch / line write-back request, held until mem_ready
//   mem_addr          28-bit line address {tag, index}
//   mem_wdata         write-back line
//   mem_rdata         fetched line
//   mem_ready         one-cycle completion pulse
module direct_mapped_cache
  import direct_mapped_cache_pkg::*;
#(
  parameter int NUM_LINES      = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            proc_read,
  input  logic                            proc_write,
  input  logic [ADDR_W-1:0]               proc_addr,
  input  logic [WORD_W-1:0]               proc_wdata,
  output logic                            proc_stall,
  output logic [WORD_W-1:0]               proc_rdata,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [MEM_ADDR_W-1:0]           mem_addr,
  output logic [WORDS_PER_LINE*WORD_W-1:0] mem_wdata,
  input  logic [WORDS_PER_LINE*WORD_W-1:0] mem_rdata,
  input  logic                            mem_ready
);

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAGW   = ADDR_W - OFFSET_W - IDX_W;
  localparam int LINEW  = WORDS_PER_LINE * WORD_W;

  cache_state_t state;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAGW-1:0]      tag_q  [NUM_LINES];
  logic [LINEW-1:0]     data_q [NUM_LINES];

  logic [OFFSET_W-1:0] offset;
  logic [IDX_W-1:0]    index;
  logic [TAGW-1:0]     tag;
  logic [6:0]          word_lsb;
  logic                req;
  logic                hit;
  logic                wr_hit;
  logic                refill;

  // The processor holds its request while stalled, so the live address
  // is used throughout the miss sequence.
  assign offset   = proc_addr[OFFSET_W-1:0];
  assign index    = proc_addr[OFFSET_W +: IDX_W];
  assign tag      = proc_addr[ADDR_W-1 -: TAGW];
  assign word_lsb = {offset, 5'b0};

  assign req    = proc_read | proc_write;
  assign hit    = req & valid_q[index] & (tag_q[index] == tag);
  assign wr_hit = (state == ST_IDLE) & hit & proc_write;
  assign refill = (state == ST_ALLOCATE) & mem_ready;

  assign proc_stall = req & ~((state == ST_IDLE) & hit);
  assign proc_rdata = data_q[index][word_lsb +: WORD_W];

  // Tag and data storage carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (refill) begin
      data_q[index] <= mem_rdata;
      tag_q[index]  <= tag;
    end else if (wr_hit) begin
      data_q[index][word_lsb +: WORD_W] <= proc_wdata;
    end
  end

  // Control FSM; memory-side outputs are registered and change only on
  // state transitions, so they stay stable for the whole transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_hit) begin
            dirty_q[index] <= 1'b1;
          end else if (req && !hit) begin
            if (valid_q[index] && dirty_q[index]) begin
              state     <= ST_WRITEBACK;
              mem_write <= 1'b1;
              mem_addr  <= {tag_q[index], index};
              mem_wdata <= data_q[index];
            end else begin
              state    <= ST_ALLOCATE;
              mem_read <= 1'b1;
              mem_addr <= {tag, index};
            end
          end
        end
        ST_WRITEBACK: begin
          if (mem_ready) begin
            state     <= ST_ALLOCATE;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
            mem_addr  <= {tag, index};
          end
        end
        ST_ALLOCATE: begin
          if (mem_ready) begin
            state          <= ST_IDLE;
            mem_read       <= 1'b0;
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_direct_mapped_cache.sv
// tb/tb_direct_mapped_cache.sv - scoreboard bench for direct_mapped_cache
module tb_direct_mapped_cache;

  localparam int K_PRD = 0;
  localparam int K_PWR = 1;
  localparam int K_MRD = 2;
  localparam int K_MWR = 3;

  typedef struct {
    int           kind;
    logic [29:0]  addr;
    logic [127:0] data;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int  errors = 0;
  int  checks = 0;
  int  cycle = 0;
  int  ready_cycle = -100;
  ev_t exp_q[$];
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;
  logic [127:0] mem_store [logic [27:0]];

  direct_mapped_cache dut (
    .clk(clk), .rst(rst),
    .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_stall(proc_stall), .proc_rdata(proc_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Unwritten lines read back as word w = {addr[23:0], w}.
  function automatic logic [127:0] line_of(input logic [27:0] a);
    logic [127:0] l;
    if (mem_store.exists(a)) return mem_store[a];
    for (int w = 0; w < 4; w++) l[32*w +: 32] = {a[23:0], 8'(w)};
    return l;
  endfunction

  // Memory: answers each request 3 cycles after it appears.
  initial begin
    int cnt;
    bit busy;
    cnt = 0; busy = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (mem_read || mem_write) begin
        if (!busy) begin busy = 1; cnt = 0; end
        cnt++;
        if (cnt == 3) begin
          busy = 0;
          mem_ready = 1'b1;
          ready_cycle = cycle;
          if (mem_read) mem_rdata = line_of(mem_addr);
          else mem_store[mem_addr] = mem_wdata;
        end
      end else begin
        busy = 0;
      end
    end
  end

  task automatic push(input int k, input logic [29:0] a, input logic [127:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input int k, input logic [29:0] a, input logic [127:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got kind=%0d addr=%h data=%h, required no event", k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr != a || e.data != d) begin
        errors++;
        $display("FAIL sb_event: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                 k, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Monitor: memory request rising edges and completed processor requests.
  always @(negedge clk) begin
    if (mem_read && !prev_rd) sb_check(K_MRD, {2'b0, mem_addr}, '0);
    if (mem_write && !prev_wr) sb_check(K_MWR, {2'b0, mem_addr}, mem_wdata);
    if ((proc_read || proc_write) && !proc_stall)
      sb_check(proc_write ? K_PWR : K_PRD, proc_addr,
               proc_write ? 128'd0 : {96'd0, proc_rdata});
    prev_rd <= mem_read;
    prev_wr <= mem_write;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req_v);
    end
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [29:0] a,
                        input logic [31:0] wd, input bit exp_hit, input string name);
    int n;
    n = 0;
    @(posedge clk); #1;
    proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = wd;
    @(negedge clk);
    while (proc_stall && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (proc_stall) begin
      errors++;
      $display("FAIL %s_timeout: stall still 1 after %0d cycles, required 0", name, n);
    end else if (exp_hit && n != 0) begin
      errors++;
      $display("FAIL %s_hit_stall: got %0d stall cycles, required 0", name, n);
    end else if (!exp_hit && cycle != ready_cycle + 1) begin
      errors++;
      $display("FAIL %s_refill_latency: got cycle %0d, required %0d", name, cycle, ready_cycle + 1);
    end
    @(posedge clk); #1;
    proc_read = 1'b0; proc_write = 1'b0;
  endtask

  initial begin
    int n;
    mem_store[28'h1] = 128'h44444444_33333333_22222222_11111111;
    rst = 1'b1; proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0; proc_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_stall", proc_stall, 0);

    // Cold read miss, then hit at offset 2.
    push(K_MRD, 30'h1, '0);
    push(K_PRD, 30'h4, 128'h11111111);
    do_req(1, 0, 30'h4, 0, 0, "cold_read");
    push(K_PRD, 30'h6, 128'h33333333);
    do_req(1, 0, 30'h6, 0, 1, "hit_read");

    // Write hit makes index 1 dirty; conflicting read evicts it.
    push(K_PWR, 30'h4, '0);
    do_req(0, 1, 30'h4, 32'hDEADBEEF, 1, "write_hit");
    push(K_MWR, 30'h1, 128'h44444444_33333333_22222222_DEADBEEF);
    push(K_MRD, 30'h9, '0);
    push(K_PRD, 30'h24, 128'h00000900);
    do_req(1, 0, 30'h24, 0, 0, "evict_read");

    // Write miss to clean index 2: allocate only, word merged after refill.
    push(K_MRD, 30'h2, '0);
    push(K_PWR, 30'h9, '0);
    do_req(0, 1, 30'h9, 32'hCAFEF00D, 0, "write_miss");
    push(K_PRD, 30'h9, 128'hCAFEF00D);
    do_req(1, 0, 30'h9, 0, 1, "merged_read");
    push(K_PRD, 30'h8, 128'h00000200);
    do_req(1, 0, 30'h8, 0, 1, "neighbor_read");

    // Read and write together act as a write; eviction carries it back.
    push(K_PWR, 30'h24, '0);
    do_req(1, 1, 30'h24, 32'h12345678, 1, "rw_write");
    push(K_PRD, 30'h25, 128'h00000901);
    do_req(1, 0, 30'h25, 0, 1, "rw_neighbor");
    push(K_MWR, 30'h9, 128'h00000903_00000902_00000901_12345678);
    push(K_MRD, 30'h11, '0);
    push(K_PRD, 30'h44, 128'h00001100);
    do_req(1, 0, 30'h44, 0, 0, "rw_evict");

    // Reset in the middle of ALLOCATE.
    push(K_MRD, 30'h4, '0);
    @(posedge clk); #1;
    proc_read = 1'b1; proc_addr = 30'h10;
    n = 0;
    @(negedge clk);
    while (!mem_read && n < 20) begin @(negedge clk); n++; end
    chk("abort_mem_read_seen", mem_read, 1);
    @(posedge clk); #1;
    rst = 1'b1; proc_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_mem_read_drop", mem_read, 0);
    chk("abort_mem_write", mem_write, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_stall_idle", proc_stall, 0);
    push(K_MRD, 30'h4, '0);
    push(K_PRD, 30'h10, 128'h00000400);
    do_req(1, 0, 30'h10, 0, 0, "after_abort");

    repeat (5) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

endmodule

// File: doc/direct_mapped_cache.md
DIRECT_MAPPED_CACHE -- requirements
Module: direct_mapped_cache

Interface
REQ-001 SHALL have parameter NUM_LINES, default 8: number of cache lines; power of two.
REQ-002 SHALL have parameter WORDS_PER_LINE, default 4: 32-bit words per line; fixed at 4.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port proc_read  input  1: processor read request.
REQ-006 SHALL have port proc_write  input  1: processor write request.
REQ-007 SHALL have port proc_addr  input  30: word address.
REQ-008 SHALL have port proc_wdata  input  32: write data.
REQ-009 SHALL have port proc_stall  output  1: request not complete this cycle.
REQ-010 SHALL have port proc_rdata  output  32: read data, valid when proc_read=1 and proc_stall=0.
REQ-011 SHALL have memory-side ports:
- mem_read  output  1: line fetch request.
- mem_write  output  1: line write-back request.
- mem_addr  output  28: line address.
- mem_wdata  output  128: write-back line data.
- mem_rdata  input  128: fetched line data.
- mem_ready  input  1: one-cycle completion pulse from memory.

Function
REQ-012 SHALL split proc_addr as offset=[1:0], index=[4:2], tag=[29:5] (25 bits) at NUM_LINES=8.
REQ-013 SHALL store word w of a line at bits [32w+31:32w] of the 128-bit line, byte order untouched.
REQ-014 SHALL be a write-back, write-allocate, direct-mapped cache, with one valid bit, one dirty bit and one tag per line.
REQ-015 SHALL implement FSM states IDLE, WRITEBACK and ALLOCATE.
REQ-016 In IDLE, hit SHALL mean valid[index] and tag match, with proc_read or proc_write asserted.
REQ-017 Read hit SHALL drive proc_rdata combinationally, with proc_stall=0 in the same cycle (zero-cycle latency).
REQ-018 Write hit SHALL complete with proc_stall=0 in the same cycle and SHALL write the word and set dirty on the next edge.
REQ-019 proc_stall SHALL equal (proc_read|proc_write) & ~(state==IDLE & hit); it SHALL be 0 when there is no request.
REQ-020 On a miss in IDLE, the FSM SHALL go to WRITEBACK if the victim line is valid and dirty, and to ALLOCATE otherwise.
REQ-021 In WRITEBACK:
- mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim line, all held stable.
- On mem_ready the FSM SHALL go to ALLOCATE.
REQ-022 In ALLOCATE:
- mem_read=1, mem_addr={request tag, index}, held stable.
- On mem_ready the line SHALL be written with mem_rdata, valid=1, dirty=0, tag updated, and the FSM SHALL go to IDLE.
REQ-023 After refill, the request SHALL hit in IDLE on the following cycle.
REQ-024 The processor SHALL hold its request stable while proc_stall=1; the cache SHALL use the live proc_addr for tag, index and offset.
REQ-025 proc_read and proc_write asserted together SHALL be treated as a write.
REQ-026 mem_read and mem_write SHALL never be high simultaneously; both SHALL be 0 in IDLE.
REQ-027 mem_ready received in IDLE SHALL be ignored.

Reset
REQ-028 On rst=1 at a clock edge:
- state SHALL become IDLE.
- All valid and dirty bits SHALL clear.
- Tags and data need no reset.
REQ-029 After reset, mem_read=0, mem_write=0, and proc_stall=0 with no request.
REQ-030 Reset during WRITEBACK or ALLOCATE SHALL abandon the transfer; memory SHALL see the request drop on the next cycle.

Structure
REQ-031 A shared package SHALL hold:
- the FSM state encoding;
- TAG_W=25, INDEX_W=3, OFFSET_W=2;
- LINE_W=128.
REQ-032 The cache SHALL be a single module with no sub-module; the storage arrays SHALL be flip-flop arrays inside it.

Verification
REQ-033 Reset, then read 0x0000_0004 with memory returning line 0x44444444_33333333_22222222_11111111 after 3 cycles -> mem_read with mem_addr=0x0000001, then proc_rdata=0x11111111 with stall=0 one cycle after mem_ready.
REQ-034 Reread of the same line at word offset 2 -> zero-stall hit, proc_rdata=0x33333333, mem_read stays 0.
REQ-035 Write 0xDEADBEEF to 0x0000_0004, then read 0x0000_0024 (same index, other tag) -> WRITEBACK with mem_addr=0x0000001 and mem_wdata word0=0xDEADBEEF, then ALLOCATE with mem_addr=0x0000009.
REQ-036 Write miss to a clean index -> ALLOCATE only, no mem_write; the word is merged after refill, and a later read returns the written value.
REQ-037 rst asserted in the middle of ALLOCATE -> mem_read=0 the next cycle, and a subsequent read of the same address misses again.
REQ-038 proc_read=proc_write=1 to a hit address with wdata=0x12345678 -> the value is written and dirty is set, and a later eviction writes 0x12345678 back.
